// File: rtl/mini_risc_pkg.sv
// Shared types and widths for the mini-RISC core.
// Used by the MUL unit and its handshake interface.
package mini_risc_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE,
    RUN
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the core and the MUL unit.
// The core is the master; the multiplier is the slave.
interface seq_multiplier_if
  import mini_risc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              busy;

  modport master (
    output start,
    output a,
    output b,
    input  result,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output result,
    output done,
    output busy
  );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one multiplier bit per clock,
// finishing early once the remaining multiplier bits are zero.
module seq_multiplier
  import mini_risc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  seq_multiplier_if.slave bus
);

  mul_state_t        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] result_q;
  logic              done_q;
  logic              busy_q;

  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // a start landing in the done cycle is dropped
          if (bus.start && !done_q) begin
            acc    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier == '0) begin
            result_q <= acc;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes
// expected result/latency, a negedge monitor pops and checks.
module tb_seq_multiplier;

  typedef struct {
    logic [31:0] res;
    int          lat;
    longint      c0;
  } exp_t;

  logic   clk;
  logic   rst;
  longint cyc;
  int     n_chk;
  int     n_pass;
  logic   prev_done;
  exp_t   sb[$];

  seq_multiplier_if #(.DATA_W(32)) bus ();

  seq_multiplier #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int bitlen(input logic [31:0] v);
    for (int i = 31; i >= 0; i--)
      if (v[i]) return i + 1;
    return 0;
  endfunction

  initial prev_done = 1'b0;

  always @(negedge clk) begin
    if (bus.done) begin
      chk("busy_with_done", {63'd0, bus.busy}, 64'd0);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_done: got result %0h want no done",
                 bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'd0, bus.result}, {32'd0, e.res});
        chk("latency", 64'(cyc - e.c0 - 1), 64'(e.lat));
      end
    end
    if (prev_done)
      chk("done_width", {63'd0, bus.done}, 64'd0);
    prev_done <= bus.done;
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    if (!bus.done) begin
      n_chk++;
      $display("FAIL timeout: got no done want done within 40 cycles");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    e.res = res;
    e.lat = bitlen(b) + 1;
    e.c0  = cyc;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
    issue(a, b, res);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    if (!bus.done) wait_done();
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #2 rst = 1'b1;
    #2;
    chk("reset_result", {32'd0, bus.result}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(32'd3, 32'd5, 32'd15);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    wait_done();

    do_op(32'd7, 32'd0, 32'd0);
    do_op(32'd0, 32'hFFFF_FFFF, 32'd0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    do_op(32'h0001_0000, 32'h0001_0000, 32'd0);

    issue(32'd6, 32'd7, 32'd42);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) break;
      bus.start = 1'b1;
      bus.a     = 32'd100 + 32'(i);
      bus.b     = 32'd3 + 32'(i);
    end
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("result_hold", {32'd0, bus.result}, 64'd42);
    end

    issue(32'd9, 32'hFF, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_result", {32'd0, bus.result}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_op(32'd2, 32'd3, 32'd6);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] p;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      p  = {32'd0, ra} * {32'd0, rb};
      do_op(ra, rb, p[31:0]);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
